// File: rtl/laplace_pkg.sv
// Shared types and helpers for the Laplace window generator.
// Pixel/cross-window typedefs and the counter-width helper.
package laplace_pkg;

    localparam int PIX_W_DEF = 8;

    typedef logic [PIX_W_DEF-1:0] pixel_t;

    typedef struct packed {
        pixel_t b;
        pixel_t d;
        pixel_t e;
        pixel_t f;
        pixel_t h;
    } cross_win_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/laplace_line_buffer.sv
// One image row of pixel storage, read-before-write on a shared column address.
// The read port is combinational so the old content is visible in the write cycle.
module laplace_line_buffer
    import laplace_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [cnt_w(DEPTH)-1:0]  addr,
    input  logic [PIX_W-1:0]         wdata,
    output logic [PIX_W-1:0]         rdata
);

    logic [PIX_W-1:0] mem_r [DEPTH];

    assign rdata = mem_r[addr];

    // Row storage write; contents need no reset since windows wait for a refill
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

endmodule

// File: rtl/laplace_window_gen.sv
// Raster pixel stream to 4-neighbour cross window for the Laplace stage.
// Optional macro LAPLACE_WIN_COORD_EN adds out_x/out_y centre-coordinate ports.
module laplace_window_gen
    import laplace_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PIX_W-1:0]         in_data,
    input  logic                     in_sof,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PIX_W-1:0]         b,
    output logic [PIX_W-1:0]         d,
    output logic [PIX_W-1:0]         e,
    output logic [PIX_W-1:0]         f,
    output logic [PIX_W-1:0]         h,
    output logic                     frame_done
`ifdef LAPLACE_WIN_COORD_EN
    ,
    output logic [cnt_w(IMG_W)-1:0]  out_x,
    output logic [cnt_w(IMG_H)-1:0]  out_y
`endif
);

    localparam int XW = cnt_w(IMG_W);
    localparam int YW = cnt_w(IMG_H);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    logic [XW-1:0]    x_r, cur_x_s;
    logic [YW-1:0]    y_r, cur_y_s;
    logic             accept_s, win_s, last_s;
    logic [PIX_W-1:0] lb0_rd_s, lb1_rd_s;
    logic [PIX_W-1:0] up_r, live_r;
    logic [PIX_W-1:0] mid_r [2];
    logic [PIX_W-1:0] b_r, d_r, e_r, f_r, h_r;
    logic             out_valid_r, last_r, frame_done_r;

    assign in_ready   = !out_valid_r || out_ready;
    assign out_valid  = out_valid_r;
    assign b          = b_r;
    assign d          = d_r;
    assign e          = e_r;
    assign f          = f_r;
    assign h          = h_r;
    assign frame_done = frame_done_r;

    // Coordinate of the incoming pixel; in_sof restarts the frame at (0,0)
    always_comb begin
        cur_x_s = x_r;
        cur_y_s = y_r;
        if (in_sof) begin
            cur_x_s = '0;
            cur_y_s = '0;
        end else begin
            cur_x_s = x_r;
            cur_y_s = y_r;
        end
        accept_s = in_valid && in_ready;
        win_s    = accept_s && (cur_x_s >= XW'(2)) && (cur_y_s >= YW'(2));
        last_s   = (cur_x_s == X_LAST) && (cur_y_s == Y_LAST);
    end

    // LB1 holds row y-1; its old content at column x shifts down into LB0 (row y-2)
    laplace_line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb1 (
        .clk   (clk),
        .we    (accept_s),
        .addr  (cur_x_s),
        .wdata (in_data),
        .rdata (lb1_rd_s)
    );

    laplace_line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb0 (
        .clk   (clk),
        .we    (accept_s),
        .addr  (cur_x_s),
        .wdata (lb1_rd_s),
        .rdata (lb0_rd_s)
    );

    // Raster position of the next pixel to be accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r <= '0;
            y_r <= '0;
        end else if (accept_s) begin
            if (cur_x_s == X_LAST) begin
                x_r <= '0;
                y_r <= (cur_y_s == Y_LAST) ? '0 : cur_y_s + YW'(1);
            end else begin
                x_r <= cur_x_s + XW'(1);
                y_r <= cur_y_s;
            end
        end
    end

    // Column taps: after an accept at column x each tap holds column x (mid_r[1]: x-1)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            up_r     <= '0;
            mid_r[0] <= '0;
            mid_r[1] <= '0;
            live_r   <= '0;
        end else if (accept_s) begin
            up_r     <= lb0_rd_s;
            mid_r[0] <= lb1_rd_s;
            mid_r[1] <= mid_r[0];
            live_r   <= in_data;
        end
    end

    // Output window register; loads on a completing accept, clears on a drained handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            last_r      <= 1'b0;
            b_r         <= '0;
            d_r         <= '0;
            e_r         <= '0;
            f_r         <= '0;
            h_r         <= '0;
        end else if (win_s) begin
            out_valid_r <= 1'b1;
            last_r      <= last_s;
            b_r         <= up_r;
            d_r         <= mid_r[1];
            e_r         <= mid_r[0];
            f_r         <= lb1_rd_s;
            h_r         <= live_r;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    // One-cycle pulse once the bottom-right interior window is taken
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= out_valid_r && out_ready && last_r;
        end
    end

`ifdef LAPLACE_WIN_COORD_EN
    logic [XW-1:0] out_x_r;
    logic [YW-1:0] out_y_r;

    assign out_x = out_x_r;
    assign out_y = out_y_r;

    // Window centre coordinate, captured alongside the window pixels
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_x_r <= '0;
            out_y_r <= '0;
        end else if (win_s) begin
            out_x_r <= cur_x_s - XW'(1);
            out_y_r <= cur_y_s - YW'(1);
        end
    end
`endif

endmodule
